pipe_regwall: RTL and testbench
===============================

Name: pipe_regwall

Overview:
- Parametrised pipeline register wall: a chain of STAGES registers, each carrying a DATA_W payload plus a valid bit.
- Each stage has its own stall and flush request, and all stage contents are exported for forwarding and hazard logic.
- Sits between the CPU datapath stages and generalises the fixed 5-stage wall. It adds per-stage stall/flush, valid tracking, bubble insertion at any boundary and an occupancy count.

Parameters:
- DATA_W, 32, payload width per stage (>=1).
- STAGES, 4, number of register stages (2..8).
- CNT_W, 16, width of the statistics counters (used only with the optional feature).

Ports:
- clock  in  1  system clock; all state updates on the falling edge, matching the rest of the CPU.
- reset  in  1  synchronous, active-high reset, sampled on the same falling edge.
- enable  in  1  global advance enable; low = every stage holds.
- in_valid  in  1  entry into stage 0 is valid.
- in_data  in  DATA_W  payload entering stage 0.
- in_ready  out  1  stage 0 will accept in_data this edge; = enable & ~hold[0] (combinational).
- stall  in  STAGES  stall[k] = stage k and everything upstream must hold.
- flush  in  STAGES  flush[k] = stage k loads a bubble.
- stage_valid  out  STAGES  registered valid bit of each stage.
- stage_data  out  STAGES*DATA_W  registered payload of each stage; stage k occupies bits [k*DATA_W +: DATA_W].
- out_valid  out  1  = stage_valid[STAGES-1].
- out_data  out  DATA_W  = payload of stage STAGES-1.
- occupancy  out  $clog2(STAGES+1)  popcount of stage_valid (combinational).

Behaviour:
- Reset: all stage_valid = 0 and all stage payloads = 0. occupancy = 0 and out_valid = 0. Reset overrides enable, stall and flush.
- hold[k] = ~enable | stall[k] | stall[k+1] | ... | stall[STAGES-1]. A stall propagates upstream only.
- Priority per stage k on each falling edge, highest first:
  1. hold[k]: stage k keeps its valid bit and payload.
  2. flush[k]: valid <= 0, payload <= 0.
  3. k>0 and hold[k-1]: bubble insertion; valid <= 0, payload <= 0.
  4. Otherwise load the upstream stage: stage k-1, or in_valid/in_data for k=0.
- A flush on a held stage is ignored. The requester must keep flush asserted until the stall clears.
- Stages downstream of the highest stalled index advance normally, so the pipeline drains below a stall.
- Stage 0 with ~hold[0] & ~flush[0] loads in_valid/in_data regardless of in_valid. An invalid entry is stored with valid = 0 but the payload is kept, not zeroed.
- Latency: an entry accepted on edge n appears at out_data after edge n+STAGES-1, provided there are no holds.
- Bubbles are always zero-payload. Downstream decode treats an all-zero payload as a NOP.
- Simultaneous stall[k] and flush[j] with j>k: stage j flushes and stage k+1 receives a bubble. Both apply in the same edge.
- enable low for several cycles: the state is frozen exactly. On re-enable, operation resumes with no lost or duplicated entries.

Optional Feature:
- Macro: PIPE_REGWALL_STATS_EN.
- When defined, add two outputs:
  - stall_cycles (CNT_W): counts edges with enable & |stall.
  - bubble_count (CNT_W): counts edges on which at least one bubble or flush is written into a previously valid stage.
- Both counters saturate at all-ones, clear on reset and are frozen while enable is low.
- When undefined, neither the ports nor the counter logic exist.

Test Plan (STAGES=4, DATA_W=32):
- Reset, then stream in_data 0x11,0x22,0x33,0x44 with in_valid=1 -> out_data=0x11 valid after edge 4; occupancy=4 at edge 4; 0x44 out at edge 7.
- Pipeline holds A,B,C,D in stages 0..3 with stall[1]=1 for 2 edges -> stages 0,1 hold A,B; stage 2 gets 0/valid 0 twice; in_ready=0; C,D drain out.
- flush[0] and flush[1] asserted for 1 edge while full with 0xA0..0xA3 -> stages 0,1 become 0/invalid; 0xA2,0xA3 continue; occupancy drops to 2, then 1 as stages 2..3 advance.
- stall[2]=1 together with flush[2]=1 -> stage 2 keeps its data (hold beats flush); stage 3 receives a bubble.
- enable=0 for 3 edges mid-stream, then 1 -> the stage_data snapshot is unchanged across the pause; the output sequence is identical to an unpaused run, shifted by 3.
- Reset asserted mid-stream with stall[3]=1 -> all valid bits 0 and payloads 0 on the next edge. With PIPE_REGWALL_STATS_EN: stall_cycles counts 2 in the stall test, bubble_count saturates at 0xFFFF under continuous flush.

Source files
------------

// File: rtl/pipe_regwall.sv
// pipe_regwall: STAGES-deep falling-edge register wall, per-stage stall/flush, STAGES-1 edge latency.
// in_ready drops whenever stage 0 is held; optional PIPE_REGWALL_STATS_EN adds saturating stall/bubble counters.
module pipe_regwall #(
  parameter int DATA_W = 32,
  parameter int STAGES = 4,
  parameter int CNT_W  = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        enable,
  input  logic                        in_valid,
  input  logic [DATA_W-1:0]           in_data,
  output logic                        in_ready,
  input  logic [STAGES-1:0]           stall,
  input  logic [STAGES-1:0]           flush,
  output logic [STAGES-1:0]           stage_valid,
  output logic [STAGES*DATA_W-1:0]    stage_data,
  output logic                        out_valid,
  output logic [DATA_W-1:0]           out_data,
  output logic [$clog2(STAGES+1)-1:0] occupancy
`ifdef PIPE_REGWALL_STATS_EN
  ,
  output logic [CNT_W-1:0]            stall_cycles,
  output logic [CNT_W-1:0]            bubble_count
`endif
);

  localparam int OCC_W = $clog2(STAGES+1);

  if (DATA_W < 1 || STAGES < 2 || STAGES > 8 || CNT_W < 1) begin : g_param_check
    $error("pipe_regwall: parameter out of range");
  end

  logic [STAGES-1:0]             hold;
  logic [STAGES-1:0]             hold_up;
  logic [STAGES-1:0]             kill;
  logic [STAGES-1:0]             up_valid;
  logic [STAGES-1:0]             valid_q;
  logic [STAGES-1:0]             valid_d;
  logic [STAGES-1:0][DATA_W-1:0] up_data;
  logic [STAGES-1:0][DATA_W-1:0] data_q;
  logic [STAGES-1:0][DATA_W-1:0] data_d;

  // A stall at index k freezes k and everything upstream of it.
  always_comb begin
    hold = '0;
    for (int k = 0; k < STAGES; k++) begin
      hold[k] = ~enable | (|(stall >> k));
    end
  end

  assign hold_up  = {hold[STAGES-2:0], 1'b0};
  assign kill     = flush | hold_up;
  assign up_valid = {valid_q[STAGES-2:0], in_valid};
  assign up_data  = {data_q[STAGES-2:0], in_data};

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    for (int k = 0; k < STAGES; k++) begin
      if (!hold[k]) begin
        if (kill[k]) begin
          valid_d[k] = 1'b0;
          data_d[k]  = '0;
        end else begin
          valid_d[k] = up_valid[k];
          data_d[k]  = up_data[k];
        end
      end
    end
  end

  always_ff @(negedge clock) begin
    if (reset) begin
      valid_q <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign in_ready    = ~hold[0];
  assign stage_valid = valid_q;
  assign stage_data  = data_q;
  assign out_valid   = valid_q[STAGES-1];
  assign out_data    = data_q[STAGES-1];

  always_comb begin
    occupancy = '0;
    for (int k = 0; k < STAGES; k++) begin
      occupancy = occupancy + OCC_W'(valid_q[k]);
    end
  end

`ifdef PIPE_REGWALL_STATS_EN
  logic [CNT_W-1:0] stall_cycles_q;
  logic [CNT_W-1:0] stall_cycles_d;
  logic [CNT_W-1:0] bubble_count_q;
  logic [CNT_W-1:0] bubble_count_d;
  logic             bubble_hit;

  // A live entry is destroyed when a non-held stage takes a bubble or flush.
  assign bubble_hit = |(valid_q & ~hold & kill);

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    bubble_count_d = bubble_count_q;
    if (enable && (|stall) && !(&stall_cycles_q)) begin
      stall_cycles_d = stall_cycles_q + 1'b1;
    end
    if (bubble_hit && !(&bubble_count_q)) begin
      bubble_count_d = bubble_count_q + 1'b1;
    end
  end

  always_ff @(negedge clock) begin
    if (reset) begin
      stall_cycles_q <= '0;
      bubble_count_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      bubble_count_q <= bubble_count_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign bubble_count = bubble_count_q;
`endif

endmodule

// File: tb/tb_pipe_regwall.sv
// Bench for pipe_regwall: scoreboard on the output stream plus directed checks of stall, flush, pause and reset.
module tb_pipe_regwall;
  localparam int DW = 32;
  localparam int ST = 4;

  logic             clock = 1'b1;
  logic             reset;
  logic             enable;
  logic             in_valid;
  logic [DW-1:0]    in_data;
  logic             in_ready;
  logic [ST-1:0]    stall;
  logic [ST-1:0]    flush;
  logic [ST-1:0]    stage_valid;
  logic [ST*DW-1:0] stage_data;
  logic             out_valid;
  logic [DW-1:0]    out_data;
  logic [2:0]       occupancy;
`ifdef PIPE_REGWALL_STATS_EN
  logic [15:0]      stall_cycles;
  logic [15:0]      bubble_count;
`endif

  int            n_chk  = 0;
  int            n_fail = 0;
  logic [DW-1:0] sb[$];
  logic          adv = 1'b0;
  logic [ST*DW-1:0] snap_exp;

  pipe_regwall #(.DATA_W(DW), .STAGES(ST), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .stall(stall), .flush(flush),
    .stage_valid(stage_valid), .stage_data(stage_data),
    .out_valid(out_valid), .out_data(out_data), .occupancy(occupancy)
`ifdef PIPE_REGWALL_STATS_EN
    , .stall_cycles(stall_cycles), .bubble_count(bubble_count)
`endif
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] sdat(input int k);
    return stage_data[k*DW +: DW];
  endfunction

  // Output stage reloads on an edge only when not reset and not held.
  always @(negedge clock) adv = enable & ~stall[ST-1] & ~reset;

  always @(posedge clock) begin
    if (adv && out_valid) begin
      if (sb.size() == 0) begin
        check_val("sb_extra_out", sb.size(), 1);
      end else begin
        check_val("sb_out", out_data, sb.pop_front());
      end
    end
  end

  task automatic step();
    @(negedge clock);
    @(posedge clock);
  endtask

  task automatic send(input logic v, input logic [DW-1:0] d, input logic push);
    in_valid = v;
    in_data  = d;
    if (push) sb.push_back(d);
    step();
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) send(1'b0, '0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; enable = 1'b1; in_valid = 1'b0; in_data = '0;
    stall = '0; flush = '0;
    step();
    step();
    check_val("rst_valid", stage_valid, 0);
    check_val("rst_data", stage_data, 0);
    check_val("rst_occ", occupancy, 0);
    check_val("rst_out_valid", out_valid, 0);
    reset = 1'b0;

    // Streaming and latency
    for (int i = 0; i < 4; i++) begin
      send(1'b1, 32'h11 * (i + 1), 1'b1);
      if (i == 2) check_val("lat_early", out_valid, 0);
    end
    check_val("lat_out_valid", out_valid, 1);
    check_val("lat_out_data", out_data, 32'h11);
    check_val("occ_full", occupancy, 4);
    drain(4);
    check_val("occ_drained", occupancy, 0);

    // stall[1]: stages 0,1 hold, stage 2 takes bubbles, downstream drains
    send(1'b1, 32'h0D, 1'b1);
    send(1'b1, 32'h0C, 1'b1);
    send(1'b1, 32'h0B, 1'b1);
    send(1'b1, 32'h0A, 1'b1);
    stall = 4'b0010; in_valid = 1'b1; in_data = 32'hEE;
    #1 check_val("stall_in_ready", in_ready, 0);
    step();
    check_val("stall1_s0", sdat(0), 32'h0A);
    check_val("stall1_s1", sdat(1), 32'h0B);
    check_val("stall1_s2", sdat(2), 32'h0);
    check_val("stall1_s3", sdat(3), 32'h0C);
    step();
    check_val("stall2_valid", stage_valid, 4'b0011);
    check_val("stall2_s2", sdat(2), 32'h0);
    check_val("stall2_s0", sdat(0), 32'h0A);
`ifdef PIPE_REGWALL_STATS_EN
    check_val("stats_stall_cycles", stall_cycles, 2);
`endif
    stall = '0;
    drain(4);

    // flush[0], flush[1] on a full pipe
    send(1'b1, 32'hA3, 1'b1);
    send(1'b1, 32'hA2, 1'b1);
    send(1'b1, 32'hA1, 1'b1);
    send(1'b1, 32'hA0, 1'b0);
    check_val("flush_pre_occ", occupancy, 4);
    flush = 4'b0011; in_valid = 1'b0; in_data = '0;
    step();
    check_val("flush_valid", stage_valid, 4'b1100);
    check_val("flush_s0", sdat(0), 0);
    check_val("flush_s1", sdat(1), 0);
    check_val("flush_s2", sdat(2), 32'hA1);
    check_val("flush_occ2", occupancy, 2);
    flush = '0;
    step();
    check_val("flush_occ1", occupancy, 1);
    drain(3);

    // stall[2] with flush[2]: hold wins, stage 3 takes a bubble
    send(1'b1, 32'hB3, 1'b1);
    send(1'b1, 32'hB2, 1'b1);
    send(1'b1, 32'hB1, 1'b1);
    send(1'b1, 32'hB0, 1'b1);
    stall = 4'b0100; flush = 4'b0100; in_valid = 1'b0; in_data = '0;
    step();
    check_val("sf_s2", sdat(2), 32'hB2);
    check_val("sf_valid", stage_valid, 4'b0111);
    check_val("sf_s3", sdat(3), 0);
    stall = '0; flush = '0;
    drain(4);

    // enable low for 3 edges freezes state exactly
    send(1'b1, 32'hC1, 1'b1);
    send(1'b1, 32'hC2, 1'b1);
    send(1'b1, 32'hC3, 1'b1);
    snap_exp = {32'h0, 32'hC1, 32'hC2, 32'hC3};
    enable = 1'b0; in_valid = 1'b1; in_data = 32'hDD;
    for (int i = 0; i < 3; i++) begin
      #1 check_val("pause_in_ready", in_ready, 0);
      step();
      check_val("pause_data", stage_data, snap_exp);
      check_val("pause_valid", stage_valid, 4'b0111);
    end
    enable = 1'b1;
    send(1'b1, 32'hC4, 1'b1);
    send(1'b1, 32'hC5, 1'b1);
    send(1'b1, 32'hC6, 1'b1);
    drain(4);
    check_val("pause_occ_end", occupancy, 0);

    // Invalid entry keeps its payload, then reset mid-stream under stall[3]
    send(1'b0, 32'h5A, 1'b0);
    check_val("inv_valid", stage_valid[0], 0);
    check_val("inv_payload", sdat(0), 32'h5A);
    send(1'b1, 32'hE1, 1'b0);
    send(1'b1, 32'hE2, 1'b0);
    stall = 4'b1000; reset = 1'b1; in_valid = 1'b1; in_data = 32'hE3;
    step();
    check_val("mid_rst_valid", stage_valid, 0);
    check_val("mid_rst_data", stage_data, 0);
    check_val("mid_rst_occ", occupancy, 0);
    check_val("mid_rst_out", out_valid, 0);
    reset = 1'b0; stall = '0;
    drain(2);

    check_val("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
